// File: rtl/wb_except_commit.sv
// Write-back stage and exception commit point: retires the MEM bundle, folds in a registered interrupt,
// and raises the pipeline-wide flush with its redirect PC. Always accepts; squashes FLUSH_GAP cycles after a flush.
module wb_except_commit #(
  parameter logic [31:0] EX_ENTRY  = 32'hbfc00380,
  parameter int          FLUSH_GAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_bd,
  input  logic        ms_ex,
  input  logic [4:0]  ms_excode,
  input  logic [31:0] ms_badvaddr,
  input  logic        ms_op_mtc0,
  input  logic        ms_op_mfc0,
  input  logic        ms_op_eret,
  input  logic [4:0]  ms_c0_rd,
  input  logic [2:0]  ms_c0_sel,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  input  logic        c0_status_ie,
  input  logic        c0_status_exl,
  input  logic [7:0]  c0_status_im,
  input  logic [7:0]  c0_cause_ip,
  input  logic [31:0] c0_epc,
  input  logic [31:0] c0_rdata,
  output logic        wb_valid,
  output logic        op_mtc0,
  output logic        op_mfc0,
  output logic        op_eret,
  output logic        wb_ex,
  output logic        wb_bd,
  output logic [4:0]  wb_excode,
  output logic [4:0]  wb_rd,
  output logic [2:0]  wb_sel,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badvaddr,
  output logic [31:0] c0_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_flush,
  output logic [31:0] ws_flush_pc,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  typedef enum logic {RUN, SQUASH} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        bd;
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic        op_mtc0;
    logic        op_mfc0;
    logic        op_eret;
    logic [4:0]  c0_rd;
    logic [2:0]  c0_sel;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } bundle_t;

  state_t     state, state_nxt;
  logic [1:0] gap_cnt, gap_cnt_nxt;
  logic       ws_valid;
  logic       int_req;
  bundle_t    bundle;
  logic       load;
  logic       ex;

  assign ws_allowin = 1'b1;
  // A bundle arriving while the flush is being raised belongs to the squashed path.
  assign load = ms_to_ws_valid && (state == RUN) && !ws_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ws_valid <= 1'b0;
      int_req  <= 1'b0;
      bundle   <= '0;
    end else begin
      ws_valid <= load;
      int_req  <= c0_status_ie & ~c0_status_exl & (|(c0_status_im & c0_cause_ip));
      if (load) begin
        bundle <= '{pc: ms_pc, bd: ms_bd, ex: ms_ex, excode: ms_excode, badvaddr: ms_badvaddr,
                    op_mtc0: ms_op_mtc0, op_mfc0: ms_op_mfc0, op_eret: ms_op_eret,
                    c0_rd: ms_c0_rd, c0_sel: ms_c0_sel, gr_we: ms_gr_we, dest: ms_dest,
                    result: ms_result};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      gap_cnt <= 2'd0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      RUN: begin
        if (ws_flush) begin
          state_nxt   = SQUASH;
          gap_cnt_nxt = 2'(FLUSH_GAP - 1);
        end
      end
      SQUASH: begin
        if (gap_cnt == 2'd0) state_nxt = RUN;
        else                 gap_cnt_nxt = gap_cnt - 2'd1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Interrupt outranks any exception or ERET already carried by the bundle.
  assign ex          = ws_valid & (int_req | bundle.ex);
  assign wb_ex       = ex;
  assign wb_excode   = int_req ? 5'd0 : bundle.excode;
  assign wb_valid    = ws_valid;
  assign op_mtc0     = ws_valid & ~ex & bundle.op_mtc0;
  assign op_mfc0     = ws_valid & ~ex & bundle.op_mfc0;
  assign op_eret     = ws_valid & ~ex & bundle.op_eret;
  assign wb_pc       = bundle.pc;
  assign wb_bd       = bundle.bd;
  assign wb_badvaddr = bundle.badvaddr;
  assign wb_rd       = bundle.c0_rd;
  assign wb_sel      = bundle.c0_sel;
  assign c0_wdata    = bundle.result;

  assign rf_we    = ws_valid & ~ex & bundle.gr_we;
  assign rf_waddr = bundle.dest;
  assign rf_wdata = op_mfc0 ? c0_rdata : bundle.result;

  assign ws_flush    = ex | op_eret;
  assign ws_flush_pc = ex ? EX_ENTRY : c0_epc;

  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_except_commit.sv
// Bench for wb_except_commit: directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_except_commit;
  localparam int GAP = 3;
  localparam logic [31:0] VEC = 32'hbfc00380;

  logic clk = 1'b0;
  logic rst;
  logic ms_to_ws_valid, ws_allowin;
  logic [31:0] ms_pc, ms_badvaddr, ms_result, c0_epc, c0_rdata;
  logic ms_bd, ms_ex, ms_op_mtc0, ms_op_mfc0, ms_op_eret, ms_gr_we;
  logic [4:0] ms_excode, ms_c0_rd, ms_dest;
  logic [2:0] ms_c0_sel;
  logic c0_status_ie, c0_status_exl;
  logic [7:0] c0_status_im, c0_cause_ip;
  logic wb_valid, op_mtc0, op_mfc0, op_eret, wb_ex, wb_bd, rf_we, ws_flush;
  logic [4:0] wb_excode, wb_rd, rf_waddr, debug_wb_rf_wnum;
  logic [2:0] wb_sel;
  logic [31:0] wb_pc, wb_badvaddr, c0_wdata, rf_wdata, ws_flush_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0] debug_wb_rf_wen;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_except_commit #(.EX_ENTRY(VEC), .FLUSH_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_bd(ms_bd), .ms_ex(ms_ex), .ms_excode(ms_excode), .ms_badvaddr(ms_badvaddr),
    .ms_op_mtc0(ms_op_mtc0), .ms_op_mfc0(ms_op_mfc0), .ms_op_eret(ms_op_eret),
    .ms_c0_rd(ms_c0_rd), .ms_c0_sel(ms_c0_sel), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_result(ms_result), .c0_status_ie(c0_status_ie), .c0_status_exl(c0_status_exl),
    .c0_status_im(c0_status_im), .c0_cause_ip(c0_cause_ip), .c0_epc(c0_epc), .c0_rdata(c0_rdata),
    .wb_valid(wb_valid), .op_mtc0(op_mtc0), .op_mfc0(op_mfc0), .op_eret(op_eret), .wb_ex(wb_ex),
    .wb_bd(wb_bd), .wb_excode(wb_excode), .wb_rd(wb_rd), .wb_sel(wb_sel), .wb_pc(wb_pc),
    .wb_badvaddr(wb_badvaddr), .c0_wdata(c0_wdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // Reference model: the instruction sitting in WB, the pending interrupt, and how many
  // more cycles incoming bundles are thrown away after a flush.
  logic m_valid, m_bd, m_ex, m_mtc0, m_mfc0, m_eret, m_we, m_int;
  logic [4:0] m_excode, m_rd, m_dest;
  logic [2:0] m_sel;
  logic [31:0] m_pc, m_bva, m_res;
  int m_blocked;
  logic e_ex, e_mtc0, e_mfc0, e_eret, e_rf_we, e_flush;
  logic [4:0] e_excode;
  logic [31:0] e_rf_wdata, e_fpc;

  task automatic calc();
    e_ex       = m_valid && (m_int || m_ex);
    e_excode   = m_int ? 5'd0 : m_excode;
    e_mtc0     = m_valid && !e_ex && m_mtc0;
    e_mfc0     = m_valid && !e_ex && m_mfc0;
    e_eret     = m_valid && !e_ex && m_eret;
    e_rf_we    = m_valid && !e_ex && m_we;
    e_rf_wdata = e_mfc0 ? c0_rdata : m_res;
    e_flush    = e_ex || e_eret;
    e_fpc      = e_ex ? VEC : c0_epc;
  endtask

  task automatic advance();
    logic accept;
    calc();
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_int = 1'b0; m_blocked = 0;
    end else begin
      accept = ms_to_ws_valid && (m_blocked == 0) && !e_flush;
      m_int  = c0_status_ie && !c0_status_exl && ((c0_status_im & c0_cause_ip) != 8'h00);
      if (e_flush) m_blocked = GAP;
      else if (m_blocked > 0) m_blocked = m_blocked - 1;
      m_valid = accept;
      if (accept) begin
        m_pc = ms_pc; m_bd = ms_bd; m_ex = ms_ex; m_excode = ms_excode; m_bva = ms_badvaddr;
        m_mtc0 = ms_op_mtc0; m_mfc0 = ms_op_mfc0; m_eret = ms_op_eret; m_rd = ms_c0_rd;
        m_sel = ms_c0_sel; m_we = ms_gr_we; m_dest = ms_dest; m_res = ms_result;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    ms_to_ws_valid = 0; ms_pc = 0; ms_bd = 0; ms_ex = 0; ms_excode = 0; ms_badvaddr = 0;
    ms_op_mtc0 = 0; ms_op_mfc0 = 0; ms_op_eret = 0; ms_c0_rd = 0; ms_c0_sel = 0;
    ms_gr_we = 0; ms_dest = 0; ms_result = 0;
  endtask

  task automatic irq_off();
    c0_status_ie = 0; c0_status_exl = 0; c0_status_im = 0; c0_cause_ip = 0;
  endtask

  task automatic send(input logic [31:0] pc, input logic we, input logic [4:0] dest, input logic [31:0] res);
    idle();
    ms_to_ws_valid = 1; ms_pc = pc; ms_gr_we = we; ms_dest = dest; ms_result = res;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < GAP + 2; i++) advance();
  endtask

  task automatic test_reset();
    idle(); irq_off(); c0_epc = 0; c0_rdata = 0;
    rst = 1;
    advance(); advance();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", wb_valid); end
    total++; if (ws_flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", ws_flush); end
    total++; if (rf_we !== 1'b0 || debug_wb_rf_wen !== 4'h0) begin bad++; $display("FAIL reset_rf_we got=%b/%h want=0", rf_we, debug_wb_rf_wen); end
    total++; if (wb_ex !== 1'b0) begin bad++; $display("FAIL reset_ex got=%b want=0", wb_ex); end
    total++; if (ws_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%b want=1", ws_allowin); end
    rst = 0;
  endtask

  task automatic test_addu();
    send(32'hbfc00010, 1, 5'd5, 32'h1234);
    advance();
    idle();
    #1;
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin bad++; $display("FAIL addu_we got=%b/%0d want=1/5", rf_we, rf_waddr); end
    total++; if (rf_wdata !== 32'h1234) begin bad++; $display("FAIL addu_wdata got=%h want=00001234", rf_wdata); end
    total++; if (ws_flush !== 1'b0) begin bad++; $display("FAIL addu_flush got=%b want=0", ws_flush); end
    total++; if (debug_wb_pc !== 32'hbfc00010 || debug_wb_rf_wen !== 4'hf) begin bad++; $display("FAIL addu_debug got=%h/%h want=bfc00010/f", debug_wb_pc, debug_wb_rf_wen); end
    advance();
  endtask

  task automatic test_syscall();
    send(32'hbfc00020, 1, 5'd7, 32'h55);
    ms_ex = 1; ms_excode = 5'd8; ms_bd = 1;
    advance();
    send(32'hbfc00024, 1, 5'd9, 32'h66);
    #1;
    total++; if (wb_ex !== 1'b1 || wb_excode !== 5'd8 || wb_bd !== 1'b1) begin bad++; $display("FAIL sys_ex got=%b/%0d/%b want=1/8/1", wb_ex, wb_excode, wb_bd); end
    total++; if (ws_flush !== 1'b1 || ws_flush_pc !== VEC) begin bad++; $display("FAIL sys_flush got=%b/%h want=1/bfc00380", ws_flush, ws_flush_pc); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL sys_rf_we got=%b want=0", rf_we); end
    advance();
    idle();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL sys_b2b_drop got=%b want=0", wb_valid); end
    drain();
  endtask

  task automatic test_eret();
    c0_epc = 32'hbfc00100;
    send(32'hbfc00030, 0, 5'd0, 32'h0);
    ms_op_eret = 1;
    advance();
    idle();
    #1;
    total++; if (op_eret !== 1'b1 || wb_ex !== 1'b0) begin bad++; $display("FAIL eret_op got=%b/%b want=1/0", op_eret, wb_ex); end
    total++; if (ws_flush !== 1'b1 || ws_flush_pc !== 32'hbfc00100) begin bad++; $display("FAIL eret_flush got=%b/%h want=1/bfc00100", ws_flush, ws_flush_pc); end
    drain();
  endtask

  task automatic test_interrupt();
    idle();
    c0_status_ie = 1; c0_status_im = 8'h80; c0_cause_ip = 8'h80;
    advance();
    send(32'hbfc00040, 0, 5'd0, 32'hdead);
    ms_op_mtc0 = 1; ms_c0_rd = 5'd12;
    advance();
    idle();
    #1;
    total++; if (wb_ex !== 1'b1 || wb_excode !== 5'd0) begin bad++; $display("FAIL int_ex got=%b/%0d want=1/0", wb_ex, wb_excode); end
    total++; if (op_mtc0 !== 1'b0) begin bad++; $display("FAIL int_mtc0 got=%b want=0", op_mtc0); end
    drain();
    // Interrupt and ERET together: the exception wins.
    c0_epc = 32'hbfc00200;
    send(32'hbfc00050, 0, 5'd0, 32'h0);
    ms_op_eret = 1;
    advance();
    idle();
    #1;
    total++; if (op_eret !== 1'b0 || wb_ex !== 1'b1) begin bad++; $display("FAIL int_eret_op got=%b/%b want=0/1", op_eret, wb_ex); end
    total++; if (ws_flush_pc !== VEC) begin bad++; $display("FAIL int_eret_pc got=%h want=bfc00380", ws_flush_pc); end
    irq_off();
    drain();
  endtask

  task automatic test_gap();
    send(32'hbfc00060, 0, 5'd0, 32'h0);
    ms_ex = 1; ms_excode = 5'd10;
    advance();
    send(32'hbfc00100, 1, 5'd1, 32'h100);
    advance();
    for (int i = 1; i <= 3; i++) begin
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL gap_drop%0d got=%b want=0", i, wb_valid); end
      send(32'hbfc00100 + 32'(i * 4), 1, 5'(i + 1), 32'(i));
      advance();
    end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL gap_drop4 got=%b want=0", wb_valid); end
    send(32'hbfc00200, 1, 5'd3, 32'hbeef);
    advance();
    idle();
    total++; if (wb_valid !== 1'b1 || wb_pc !== 32'hbfc00200 || rf_wdata !== 32'hbeef) begin bad++; $display("FAIL gap_commit got=%b/%h/%h want=1/bfc00200/0000beef", wb_valid, wb_pc, rf_wdata); end
    advance();
  endtask

  task automatic test_rst_squash();
    send(32'hbfc00070, 0, 5'd0, 32'h0);
    ms_ex = 1; ms_excode = 5'd4;
    advance();
    idle();
    advance();
    c0_epc = 0;
    rst = 1;
    send(32'hbfc00080, 1, 5'd2, 32'h77);
    advance();
    rst = 0;
    idle();
    #1;
    total++; if (wb_valid !== 1'b0 || ws_flush !== 1'b0 || rf_we !== 1'b0 || wb_ex !== 1'b0) begin bad++; $display("FAIL rst_sq_out got=%b%b%b%b want=0000", wb_valid, ws_flush, rf_we, wb_ex); end
    total++; if (wb_pc !== 32'h0 || rf_wdata !== 32'h0) begin bad++; $display("FAIL rst_sq_payload got=%h/%h want=0/0", wb_pc, rf_wdata); end
    send(32'hbfc00090, 1, 5'd6, 32'h99);
    advance();
    idle();
    total++; if (wb_valid !== 1'b1 || rf_we !== 1'b1 || wb_pc !== 32'hbfc00090) begin bad++; $display("FAIL rst_sq_first got=%b/%b/%h want=1/1/bfc00090", wb_valid, rf_we, wb_pc); end
    advance();
  endtask

  task automatic test_random();
    int kind;
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      ms_to_ws_valid = ($urandom_range(0, 3) != 0);
      ms_pc = $urandom; ms_bd = 1'($urandom); ms_badvaddr = $urandom; ms_result = $urandom;
      ms_ex = ($urandom_range(0, 9) == 0); ms_excode = 5'($urandom);
      kind = $urandom_range(0, 9);
      ms_op_mtc0 = (kind == 0); ms_op_mfc0 = (kind == 1); ms_op_eret = (kind == 2);
      ms_gr_we = (kind == 1) || (kind > 2 && $urandom_range(0, 3) != 0);
      ms_c0_rd = 5'($urandom); ms_c0_sel = 3'($urandom); ms_dest = 5'($urandom);
      c0_status_ie = ($urandom_range(0, 7) == 0); c0_status_exl = ($urandom_range(0, 3) == 0);
      c0_status_im = 8'($urandom); c0_cause_ip = 8'($urandom);
      c0_epc = $urandom; c0_rdata = $urandom;
      #1;
      calc();
      total++; if (wb_valid !== m_valid) begin bad++; $display("FAIL rnd%0d valid got=%b want=%b", n, wb_valid, m_valid); end
      total++; if (wb_ex !== e_ex) begin bad++; $display("FAIL rnd%0d ex got=%b want=%b", n, wb_ex, e_ex); end
      total++; if ({op_mtc0, op_mfc0, op_eret} !== {e_mtc0, e_mfc0, e_eret}) begin bad++; $display("FAIL rnd%0d c0ops got=%b%b%b want=%b%b%b", n, op_mtc0, op_mfc0, op_eret, e_mtc0, e_mfc0, e_eret); end
      total++; if (rf_we !== e_rf_we || debug_wb_rf_wen !== {4{e_rf_we}}) begin bad++; $display("FAIL rnd%0d rf_we got=%b/%h want=%b", n, rf_we, debug_wb_rf_wen, e_rf_we); end
      total++; if (ws_flush !== e_flush) begin bad++; $display("FAIL rnd%0d flush got=%b want=%b", n, ws_flush, e_flush); end
      if (e_ex) begin
        total++; if (wb_excode !== e_excode) begin bad++; $display("FAIL rnd%0d excode got=%0d want=%0d", n, wb_excode, e_excode); end
      end
      if (e_flush) begin
        total++; if (ws_flush_pc !== e_fpc) begin bad++; $display("FAIL rnd%0d flush_pc got=%h want=%h", n, ws_flush_pc, e_fpc); end
      end
      if (e_rf_we) begin
        total++; if (rf_waddr !== m_dest || rf_wdata !== e_rf_wdata) begin bad++; $display("FAIL rnd%0d rf_w got=%0d/%h want=%0d/%h", n, rf_waddr, rf_wdata, m_dest, e_rf_wdata); end
      end
      if (m_valid) begin
        total++; if (wb_pc !== m_pc || wb_bd !== m_bd || wb_badvaddr !== m_bva) begin bad++; $display("FAIL rnd%0d pc_bd_bva got=%h/%b/%h want=%h/%b/%h", n, wb_pc, wb_bd, wb_badvaddr, m_pc, m_bd, m_bva); end
        total++; if (wb_rd !== m_rd || wb_sel !== m_sel || c0_wdata !== m_res) begin bad++; $display("FAIL rnd%0d c0addr got=%0d/%0d/%h want=%0d/%0d/%h", n, wb_rd, wb_sel, c0_wdata, m_rd, m_sel, m_res); end
      end
      advance();
    end
    rst = 0;
    irq_off();
  endtask

  initial begin
    rst = 1;
    idle(); irq_off(); c0_epc = 0; c0_rdata = 0;
    m_valid = 0; m_int = 0; m_blocked = 0;
    @(negedge clk);
    test_reset();
    test_addu();
    test_syscall();
    test_eret();
    test_interrupt();
    test_gap();
    test_rst_squash();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
